// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory controller: access-mode encodings,
// FSM state type and the word-boundary split predicate.
package lsu_pkg;

    // Access mode encodings as presented by decode (modeBU)
    localparam logic [2:0] MODE_NONE  = 3'b000;
    localparam logic [2:0] MODE_WORD  = 3'b001;
    localparam logic [2:0] MODE_HALF  = 3'b010;
    localparam logic [2:0] MODE_BYTE  = 3'b011;
    localparam logic [2:0] MODE_HALFU = 3'b100;
    localparam logic [2:0] MODE_BYTEU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    // True when the access straddles a word boundary and needs two memory beats
    function automatic logic is_split(input logic [2:0] mode, input logic [1:0] offset);
        return ((mode == MODE_WORD) && (offset != 2'd0)) ||
               (((mode == MODE_HALF) || (mode == MODE_HALFU)) && (offset == 2'd3));
    endfunction

    // Encodings outside 001..101 are treated as no-ops
    function automatic logic is_valid_mode(input logic [2:0] mode);
        return (mode >= MODE_WORD) && (mode <= MODE_BYTEU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering shared by both memory beats: byte-enable generation,
// write-data shifting and load merge with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            i_mode,
    input  logic [1:0]            i_offset,
    input  logic                  i_beat1,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata_lo,
    input  logic [DATA_WIDTH-1:0] i_rdata_hi,
    output logic [3:0]            o_be,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [3:0]              w_be_base;
    logic [7:0]              w_be_wide;
    logic [2*DATA_WIDTH-1:0] w_wdata_wide;
    logic [DATA_WIDTH-1:0]   w_rdata_shift;
    logic [4:0]              w_shamt;

    assign w_shamt = {i_offset, 3'b000};

    // Unshifted enable pattern for the access size
    always_comb begin
        w_be_base = 4'b0000;
        case (i_mode)
            MODE_WORD:              w_be_base = 4'b1111;
            MODE_HALF, MODE_HALFU:  w_be_base = 4'b0011;
            MODE_BYTE, MODE_BYTEU:  w_be_base = 4'b0001;
            default:                w_be_base = 4'b0000;
        endcase
    end

    // Shifting into a double-width window: the low half is beat 0, the spill-over
    // into the high half is exactly what beat 1 must carry.
    assign w_be_wide    = {4'b0000, w_be_base} << i_offset;
    assign w_wdata_wide = {{DATA_WIDTH{1'b0}}, i_wdata} << w_shamt;
    assign o_be         = i_beat1 ? w_be_wide[7:4] : w_be_wide[3:0];
    assign o_wdata      = i_beat1 ? w_wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : w_wdata_wide[DATA_WIDTH-1:0];

    // Bytes from the second word only survive the size mask when the access was split
    assign w_rdata_shift = DATA_WIDTH'({i_rdata_hi, i_rdata_lo} >> w_shamt);

    // Mask to the access size and extend
    always_comb begin
        o_rdata = '0;
        case (i_mode)
            MODE_WORD:  o_rdata = w_rdata_shift;
            MODE_HALF:  o_rdata = {{(DATA_WIDTH-16){w_rdata_shift[15]}}, w_rdata_shift[15:0]};
            MODE_BYTE:  o_rdata = {{(DATA_WIDTH-8){w_rdata_shift[7]}}, w_rdata_shift[7:0]};
            MODE_HALFU: o_rdata = {{(DATA_WIDTH-16){1'b0}}, w_rdata_shift[15:0]};
            MODE_BYTEU: o_rdata = {{(DATA_WIDTH-8){1'b0}}, w_rdata_shift[7:0]};
            default:    o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: runs one request against a word-addressed memory
// over a req/ack handshake, splitting word-crossing accesses into two beats and
// stalling the pipeline until the response.
// Optional: define MISALIGN_TRAP_EN to reject split accesses with rsp_err instead.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                r_state, w_state_d;

    logic                  r_write;
    logic [2:0]            r_mode;
    logic [1:0]            r_offset;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0,    w_rdata0_d;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_d;
    logic                  r_mem_req,   w_mem_req_d;
    logic                  r_mem_we,    w_mem_we_d;
    logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_d;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_d;
    logic [3:0]            r_mem_be,    w_mem_be_d;
    logic                  w_capture;

`ifdef MISALIGN_TRAP_EN
    logic                  r_rsp_err,   w_rsp_err_d;
`endif

    logic [2:0]            w_sel_mode;
    logic [1:0]            w_sel_offset;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [DATA_WIDTH-1:0] w_lane_wdata;
    logic [DATA_WIDTH-1:0] w_lane_rdata;
    logic [DATA_WIDTH-1:0] w_rdata_lo;
    logic [3:0]            w_lane_be;

    // In IDLE the aligner sees the live request so beat 0 can be registered at accept
    assign w_sel_mode   = (r_state == IDLE) ? req_mode       : r_mode;
    assign w_sel_offset = (r_state == IDLE) ? req_addr[1:0]  : r_offset;
    assign w_sel_wdata  = (r_state == IDLE) ? req_wdata      : r_wdata;
    assign w_rdata_lo   = (r_state == BEAT1) ? r_rdata0      : mem_rdata;

    lsu_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_align (
        .i_mode     (w_sel_mode),
        .i_offset   (w_sel_offset),
        .i_beat1    (r_state == BEAT1),
        .i_wdata    (w_sel_wdata),
        .i_rdata_lo (w_rdata_lo),
        .i_rdata_hi (mem_rdata),
        .o_be       (w_lane_be),
        .o_wdata    (w_lane_wdata),
        .o_rdata    (w_lane_rdata)
    );

    // Next-state and next memory-interface values
    always_comb begin
        w_state_d     = r_state;
        w_mem_req_d   = r_mem_req;
        w_mem_we_d    = r_mem_we;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        w_mem_be_d    = r_mem_be;
        w_rdata0_d    = r_rdata0;
        w_rsp_rdata_d = r_rsp_rdata;
        w_capture     = 1'b0;
`ifdef MISALIGN_TRAP_EN
        w_rsp_err_d   = r_rsp_err;
`endif
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_capture     = 1'b1;
                    w_rsp_rdata_d = '0;
`ifdef MISALIGN_TRAP_EN
                    w_rsp_err_d   = 1'b0;
`endif
                    if (!is_valid_mode(req_mode)) begin
                        w_state_d = RESP;
`ifdef MISALIGN_TRAP_EN
                    end else if (is_split(req_mode, req_addr[1:0])) begin
                        w_state_d   = RESP;
                        w_rsp_err_d = 1'b1;
`endif
                    end else begin
                        w_state_d     = BEAT0;
                        w_mem_req_d   = 1'b1;
                        w_mem_we_d    = req_write;
                        w_mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        w_mem_wdata_d = req_write ? w_lane_wdata : '0;
                        w_mem_be_d    = req_write ? w_lane_be : 4'b0000;
                    end
                end
            end
            BEAT0: begin
                if (r_mem_req && mem_ack) begin
                    w_mem_req_d = 1'b0;
                    w_mem_we_d  = 1'b0;
                    if (is_split(r_mode, r_offset)) begin
                        w_state_d  = BEAT1;
                        w_rdata0_d = mem_rdata;
                    end else begin
                        w_state_d = RESP;
                        if (!r_write) begin
                            w_rsp_rdata_d = w_lane_rdata;
                        end
                    end
                end
            end
            BEAT1: begin
                // First BEAT1 cycle is the mandatory idle gap; the second beat issues after it
                if (!r_mem_req) begin
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = r_write;
                    w_mem_addr_d  = r_mem_addr + ADDR_WIDTH'(4);
                    w_mem_wdata_d = r_write ? w_lane_wdata : '0;
                    w_mem_be_d    = r_write ? w_lane_be : 4'b0000;
                end else if (mem_ack) begin
                    w_mem_req_d = 1'b0;
                    w_mem_we_d  = 1'b0;
                    w_state_d   = RESP;
                    if (!r_write) begin
                        w_rsp_rdata_d = w_lane_rdata;
                    end
                end
            end
            RESP: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Request capture, memory interface and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_mode      <= MODE_NONE;
            r_offset    <= 2'b00;
            r_wdata     <= '0;
            r_rdata0    <= '0;
            r_rsp_rdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= 4'b0000;
        end else begin
            if (w_capture) begin
                r_write  <= req_write;
                r_mode   <= req_mode;
                r_offset <= req_addr[1:0];
                r_wdata  <= req_wdata;
            end
            r_rdata0    <= w_rdata0_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            r_mem_req   <= w_mem_req_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_mem_be    <= w_mem_be_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Misalignment error flag, valid alongside rsp_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_rsp_err_d;
        end
    end
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign stall     = (r_state == BEAT0) || (r_state == BEAT1);
    assign rsp_rdata = r_rsp_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule
